// File: rtl/computer_mc_if.sv
// rtl/computer_mc_if.sv - memory, status and debug bundle for the computer_mc core
//
// Purpose: groups the instruction-memory port, the data-memory request
// handshake and the status/debug outputs of computer_mc.
// Ports (master = core side):
//   imem_addr  out  PC_W       instruction address (the PC)
//   imem_data  in   7+DATA_W   {opcode[6:0], literal}, combinational from imem_addr
//   dmem_req   out  1          data request, high only in MEM
//   dmem_we    out  1          1 = write, 0 = read
//   dmem_addr  out  DATA_W     data address
//   dmem_wdata out  DATA_W     write data
//   dmem_ack   in   1          completes the request in the cycle it is high
//   dmem_rdata in   DATA_W     read data, valid with dmem_ack
//   halted     out  1          core is in HALT
//   err        out  1          sticky stack overflow/underflow indication
//   dbg_a/b    out  DATA_W     current regA / regB
interface computer_mc_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 7
);
  logic [PC_W-1:0]     imem_addr;
  logic [6+DATA_W:0]   imem_data;
  logic                dmem_req;
  logic                dmem_we;
  logic [DATA_W-1:0]   dmem_addr;
  logic [DATA_W-1:0]   dmem_wdata;
  logic                dmem_ack;
  logic [DATA_W-1:0]   dmem_rdata;
  logic                halted;
  logic                err;
  logic [DATA_W-1:0]   dbg_a;
  logic [DATA_W-1:0]   dbg_b;

  modport master (
    output imem_addr, input imem_data,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata,
    output halted, err, dbg_a, dbg_b
  );

  modport slave (
    input  imem_addr, output imem_data,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata,
    input  halted, err, dbg_a, dbg_b
  );
endinterface

// File: rtl/computer_mc.sv
// rtl/computer_mc.sv - multi-cycle accumulator core with call stack
//
// Purpose: FETCH/EXEC/MEM/HALT multi-cycle core. Non-memory instructions take
// 2 cycles, loads/stores 3 + wait cycles.
// Ports: clk, rst_n (async, active-low), bus (computer_mc_if.master).
//
// Opcode map (op[6:0]):
//   000_ooo_s  ALU, A <= A op (s ? lit : B); ooo: 0 ADD 1 SUB 2 AND 3 OR 4 XOR
//   001000_d   MOV d,lit        (d: 0 = A, 1 = B)
//   0010010    MOV A,B    0010011 MOV B,A
//   010000_d   LOAD d,[lit]     010001_d  STORE d,[lit]
//   0110_ccc   jump to lit; ccc: 0 always 1 Z 2 !Z 3 C 4 !C 5 N 6 V 7 never
//   1111101 CALL   1111110 RET   1111111 HALT   anything else: NOP
// SUB sets C on borrow; logic ops clear C and V.
module computer_mc #(
  parameter int DATA_W      = 8,
  parameter int PC_W        = 7,
  parameter int STACK_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  computer_mc_if.master bus
);
  localparam int SP_W = $clog2(STACK_DEPTH) + 1;
  localparam int IR_W = 7 + DATA_W;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;
  state_t state, state_nxt;

  logic [IR_W-1:0]   ir;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] reg_a, reg_b;
  logic              flag_z, flag_n, flag_c, flag_v;
  logic [PC_W-1:0]   stack [STACK_DEPTH];
  logic [SP_W-1:0]   sp;
  logic              err_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_addr_q, mem_wdata_q;
  logic              req, halt_o;

  // decode
  logic [6:0]        opcode;
  logic [DATA_W-1:0] lit;
  logic [PC_W-1:0]   lit_pc, pc_inc;
  logic [SP_W-1:0]   sp_m1;
  logic is_alu, is_mov_lit, is_mov_reg, is_load, is_store, is_mem;
  logic is_jump, is_call, is_ret, is_halt, stack_full, stack_empty, fault;

  assign opcode      = ir[IR_W-1:DATA_W];
  assign lit         = ir[DATA_W-1:0];
  assign lit_pc      = PC_W'(lit);
  assign pc_inc      = pc + PC_W'(1);
  assign sp_m1       = sp - SP_W'(1);
  assign is_alu      = (opcode[6:4] == 3'b000) && (opcode[3:1] <= 3'd4);
  assign is_mov_lit  = (opcode[6:1] == 6'b001000);
  assign is_mov_reg  = (opcode[6:1] == 6'b001001);
  assign is_load     = (opcode[6:1] == 6'b010000);
  assign is_store    = (opcode[6:1] == 6'b010001);
  assign is_mem      = is_load | is_store;
  assign is_jump     = (opcode[6:3] == 4'b0110);
  assign is_call     = (opcode == 7'b1111101);
  assign is_ret      = (opcode == 7'b1111110);
  assign is_halt     = (opcode == 7'b1111111);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign fault       = (is_call && stack_full) || (is_ret && stack_empty);

  // ALU, carry/overflow taken at DATA_W
  logic [DATA_W-1:0] alu_b, alu_y;
  logic [DATA_W:0]   sum, diff;
  logic              alu_c, alu_v, take;

  assign alu_b = opcode[0] ? lit : reg_b;
  assign sum   = {1'b0, reg_a} + {1'b0, alu_b};
  assign diff  = {1'b0, reg_a} - {1'b0, alu_b};

  always_comb begin
    alu_y = sum[DATA_W-1:0];
    alu_c = sum[DATA_W];
    alu_v = (reg_a[DATA_W-1] == alu_b[DATA_W-1]) && (sum[DATA_W-1] != reg_a[DATA_W-1]);
    case (opcode[3:1])
      3'd1: begin
        alu_y = diff[DATA_W-1:0];
        alu_c = diff[DATA_W];
        alu_v = (reg_a[DATA_W-1] != alu_b[DATA_W-1]) && (diff[DATA_W-1] != reg_a[DATA_W-1]);
      end
      3'd2: begin alu_y = reg_a & alu_b; alu_c = 1'b0; alu_v = 1'b0; end
      3'd3: begin alu_y = reg_a | alu_b; alu_c = 1'b0; alu_v = 1'b0; end
      3'd4: begin alu_y = reg_a ^ alu_b; alu_c = 1'b0; alu_v = 1'b0; end
      default: ;
    endcase
  end

  always_comb begin
    take = 1'b0;
    case (opcode[2:0])
      3'd0: take = 1'b1;
      3'd1: take = flag_z;
      3'd2: take = ~flag_z;
      3'd3: take = flag_c;
      3'd4: take = ~flag_c;
      3'd5: take = flag_n;
      3'd6: take = flag_v;
      default: take = 1'b0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: state_nxt = EXEC;
      EXEC: begin
        if (is_halt || fault) state_nxt = HALT;
        else if (is_mem)      state_nxt = MEM;
        else                  state_nxt = FETCH;
      end
      MEM:     if (bus.dmem_ack) state_nxt = FETCH;
      default: state_nxt = HALT;
    endcase
  end

  // FSM: outputs; req comes straight from state so reset drops it at once
  always_comb begin
    req    = 1'b0;
    halt_o = 1'b0;
    case (state)
      MEM:     req    = 1'b1;
      HALT:    halt_o = 1'b1;
      default: ;
    endcase
  end

  // datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir          <= '0;
      pc          <= '0;
      reg_a       <= '0;
      reg_b       <= '0;
      {flag_z, flag_n, flag_c, flag_v} <= 4'b0;
      sp          <= '0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state)
        FETCH: ir <= bus.imem_data;
        EXEC: begin
          if (is_mem) begin
            // memory ops only latch the request; PC moves on ack
            mem_addr_q  <= lit;
            mem_wdata_q <= opcode[0] ? reg_b : reg_a;
            mem_we_q    <= is_store;
          end else if (fault) begin
            err_q <= 1'b1;
          end else if (!is_halt) begin
            if (is_alu) begin
              reg_a  <= alu_y;
              flag_z <= (alu_y == '0);
              flag_n <= alu_y[DATA_W-1];
              flag_c <= alu_c;
              flag_v <= alu_v;
            end
            if (is_mov_lit) begin
              if (opcode[0]) reg_b <= lit;
              else           reg_a <= lit;
            end
            if (is_mov_reg) begin
              if (opcode[0]) reg_b <= reg_a;
              else           reg_a <= reg_b;
            end
            if (is_call) begin
              pc <= lit_pc;
              sp <= sp + SP_W'(1);
            end else if (is_ret) begin
              pc <= stack[sp_m1[SP_W-2:0]];
              sp <= sp_m1;
            end else if (is_jump && take) begin
              pc <= lit_pc;
            end else begin
              pc <= pc_inc;
            end
          end
        end
        MEM: begin
          if (bus.dmem_ack) begin
            pc <= pc_inc;
            if (is_load) begin
              if (opcode[0]) reg_b <= bus.dmem_rdata;
              else           reg_a <= bus.dmem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // return-address storage; only sp needs reset
  always_ff @(posedge clk) begin
    if (state == EXEC && is_call && !stack_full)
      stack[sp[SP_W-2:0]] <= pc_inc;
  end

  assign bus.imem_addr  = pc;
  assign bus.dmem_req   = req;
  assign bus.dmem_we    = mem_we_q;
  assign bus.dmem_addr  = mem_addr_q;
  assign bus.dmem_wdata = mem_wdata_q;
  assign bus.halted     = halt_o;
  assign bus.err        = err_q;
  assign bus.dbg_a      = reg_a;
  assign bus.dbg_b      = reg_b;
endmodule

// File: tb/tb_computer_mc.sv
// tb/tb_computer_mc.sv - self-checking bench for computer_mc
module tb_computer_mc;
  localparam int DW = 8;
  localparam int PW = 7;
  localparam int SD = 4;

  localparam logic [6:0] OP_ADD_L = 7'h01, OP_MOV_A = 7'h10, OP_MOV_B = 7'h11;
  localparam logic [6:0] OP_LD_A = 7'h20, OP_ST_A = 7'h22;
  localparam logic [6:0] OP_JZ = 7'h31, OP_JC = 7'h33, OP_NOP = 7'h40;
  localparam logic [6:0] OP_CALL = 7'h7D, OP_RET = 7'h7E, OP_HALT = 7'h7F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int wait_cycles = -1;

  computer_mc_if #(.DATA_W(DW), .PC_W(PW)) bus ();
  computer_mc #(.DATA_W(DW), .PC_W(PW), .STACK_DEPTH(SD)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [14:0] imem [128];
  logic [7:0]  dut_mem [256];
  assign bus.imem_data = imem[bus.imem_addr];

  // reference model: instruction-level state
  int m_pc, m_a, m_b;
  bit m_z, m_n, m_c, m_v, m_halt, m_err;
  int m_stack[$];
  int mdm [256];

  function automatic logic [14:0] ins(input logic [6:0] op, input logic [7:0] lit);
    return {op, lit};
  endfunction

  function automatic logic [14:0] rand_ins();
    int r;
    logic [6:0] op;
    r = int'($urandom_range(0, 99));
    if (r < 40)      op = 7'($urandom_range(0, 9));
    else if (r < 55) op = 7'(16 + $urandom_range(0, 3));
    else if (r < 70) op = 7'(32 + $urandom_range(0, 3));
    else if (r < 88) op = 7'(48 + $urandom_range(0, 6));
    else if (r < 93) op = OP_CALL;
    else if (r < 97) op = OP_RET;
    else if (r < 99) op = OP_NOP;
    else             op = OP_HALT;
    return {op, 8'($urandom)};
  endfunction

  task automatic fill_nop();
    for (int i = 0; i < 128; i++) imem[i] = ins(OP_NOP, 8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;
    m_pc = 0; m_a = 0; m_b = 0;
    {m_z, m_n, m_c, m_v, m_halt, m_err} = 6'b0;
    m_stack.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic model_exec(input logic [14:0] w);
    int op, lit, opnd, sa, so, r, nxt;
    bit tk;
    op = int'(w[14:8]);
    lit = int'(w[7:0]);
    nxt = (m_pc + 1) % 128;
    if (op <= 9) begin
      opnd = (op % 2 == 1) ? lit : m_b;
      sa = (m_a >= 128) ? m_a - 256 : m_a;
      so = (opnd >= 128) ? opnd - 256 : opnd;
      r = 0; m_c = 0; m_v = 0;
      case (op / 2)
        0: begin r = (m_a + opnd) % 256; m_c = (m_a + opnd > 255); m_v = (sa + so > 127) || (sa + so < -128); end
        1: begin r = (m_a - opnd + 256) % 256; m_c = (m_a < opnd); m_v = (sa - so > 127) || (sa - so < -128); end
        2: r = m_a & opnd;
        3: r = m_a | opnd;
        default: r = m_a ^ opnd;
      endcase
      m_a = r; m_z = (r == 0); m_n = (r >= 128);
      m_pc = nxt;
    end else begin
      case (op)
        'h10: m_a = lit;
        'h11: m_b = lit;
        'h12: m_a = m_b;
        'h13: m_b = m_a;
        'h20: m_a = mdm[lit];
        'h21: m_b = mdm[lit];
        'h22: mdm[lit] = m_a;
        'h23: mdm[lit] = m_b;
        default: ;
      endcase
      if (op >= 'h30 && op <= 'h37) begin
        case (op - 'h30)
          0: tk = 1; 1: tk = m_z; 2: tk = !m_z; 3: tk = m_c;
          4: tk = !m_c; 5: tk = m_n; 6: tk = m_v; default: tk = 0;
        endcase
        if (tk) nxt = lit % 128;
      end
      if (op == 'h7F) m_halt = 1;
      else if (op == 'h7D && m_stack.size() == SD) begin m_halt = 1; m_err = 1; end
      else if (op == 'h7E && m_stack.size() == 0) begin m_halt = 1; m_err = 1; end
      else if (op == 'h7D) begin m_stack.push_back(nxt); m_pc = lit % 128; end
      else if (op == 'h7E) m_pc = m_stack.pop_back();
      else m_pc = nxt;
    end
  endtask

  // runs one instruction on the DUT and the model; ok collects bus protocol observations
  task automatic step_instr(output bit ok);
    logic [14:0] w;
    logic [6:0] op;
    int wt;
    bit exp_we;
    logic [7:0] exp_addr, exp_wd;
    w = imem[m_pc];
    op = w[14:8];
    ok = 1;
    if (bus.imem_addr !== 7'(m_pc) || bus.dmem_req !== 1'b0) ok = 0;
    @(posedge clk); #1;
    if (bus.dmem_req !== 1'b0) ok = 0;
    @(posedge clk); #1;
    if (op >= 7'h20 && op <= 7'h23) begin
      wt = (wait_cycles < 0) ? int'($urandom_range(0, 3)) : wait_cycles;
      exp_we = op[1];
      exp_addr = w[7:0];
      exp_wd = op[0] ? 8'(m_b) : 8'(m_a);
      for (int k = 0; k <= wt; k++) begin
        if (bus.dmem_req !== 1'b1 || bus.dmem_we !== exp_we || bus.dmem_addr !== exp_addr ||
            (exp_we && bus.dmem_wdata !== exp_wd) || bus.imem_addr !== 7'(m_pc)) ok = 0;
        if (k == wt) begin
          bus.dmem_ack = 1'b1;
          if (bus.dmem_we) dut_mem[bus.dmem_addr] = bus.dmem_wdata;
          bus.dmem_rdata = dut_mem[bus.dmem_addr];
        end else begin
          bus.dmem_ack = 1'b0;
          bus.dmem_rdata = 8'($urandom);
        end
        @(posedge clk); #1;
      end
      bus.dmem_ack = 1'b0;
    end
    model_exec(w);
  endtask

  task automatic test_reset();
    fill_nop();
    do_reset();
    total++; if (bus.imem_addr !== 7'h00) begin bad++; $display("FAIL reset_pc got=%h want=00", bus.imem_addr); end
    total++; if (bus.dbg_a !== 8'h00 || bus.dbg_b !== 8'h00) begin bad++; $display("FAIL reset_regs got=%h/%h want=00/00", bus.dbg_a, bus.dbg_b); end
    total++; if ({bus.halted, bus.err, bus.dmem_req, bus.dmem_we} !== 4'b0000) begin bad++; $display("FAIL reset_ctrl got=%b want=0000", {bus.halted, bus.err, bus.dmem_req, bus.dmem_we}); end
  endtask

  task automatic test_add_literal();
    fill_nop();
    imem[0] = ins(OP_MOV_A, 8'd5);
    imem[1] = ins(OP_ADD_L, 8'd3);
    imem[2] = ins(OP_JZ, 8'h40);
    imem[3] = ins(OP_JC, 8'h40);
    imem[4] = ins(OP_HALT, 8'h00);
    do_reset();
    repeat (4) @(posedge clk); #1;
    total++; if (bus.dbg_a !== 8'd8) begin bad++; $display("FAIL add_lit_a got=%h want=08", bus.dbg_a); end
    repeat (4) @(posedge clk); #1;
    total++; if (bus.imem_addr !== 7'd4) begin bad++; $display("FAIL add_lit_zc_clear pc got=%h want=04", bus.imem_addr); end
    repeat (2) @(posedge clk); #1;
    total++; if (bus.halted !== 1'b1 || bus.err !== 1'b0 || bus.imem_addr !== 7'd4) begin bad++; $display("FAIL add_lit_halt got=%b%b pc=%h want=10 pc=04", bus.halted, bus.err, bus.imem_addr); end
  endtask

  task automatic test_carry_flags();
    fill_nop();
    imem[0] = ins(OP_MOV_A, 8'hFF);
    imem[1] = ins(OP_ADD_L, 8'h01);
    imem[2] = ins(OP_MOV_B, 8'h07);
    imem[3] = ins(OP_JZ, 8'h10);
    imem[16] = ins(OP_JC, 8'h20);
    imem[32] = ins(OP_HALT, 8'h00);
    do_reset();
    repeat (4) @(posedge clk); #1;
    total++; if (bus.dbg_a !== 8'h00) begin bad++; $display("FAIL carry_a got=%h want=00", bus.dbg_a); end
    repeat (2) @(posedge clk); #1;
    total++; if (bus.dbg_b !== 8'h07) begin bad++; $display("FAIL carry_movb got=%h want=07", bus.dbg_b); end
    repeat (2) @(posedge clk); #1;
    total++; if (bus.imem_addr !== 7'h10) begin bad++; $display("FAIL carry_z_held pc got=%h want=10", bus.imem_addr); end
    repeat (2) @(posedge clk); #1;
    total++; if (bus.imem_addr !== 7'h20) begin bad++; $display("FAIL carry_c_held pc got=%h want=20", bus.imem_addr); end
  endtask

  task automatic test_store_wait();
    int hi;
    bit stable;
    fill_nop();
    imem[0] = ins(OP_MOV_A, 8'h5A);
    imem[1] = ins(OP_ST_A, 8'h10);
    imem[2] = ins(OP_HALT, 8'h00);
    do_reset();
    repeat (4) @(posedge clk); #1;
    hi = 0;
    stable = 1;
    for (int k = 0; k < 4; k++) begin
      if (bus.dmem_req === 1'b1) hi++;
      if (bus.dmem_addr !== 8'h10 || bus.dmem_wdata !== 8'h5A || bus.dmem_we !== 1'b1 || bus.imem_addr !== 7'd1) stable = 0;
      bus.dmem_ack = (k == 3);
      @(posedge clk); #1;
    end
    bus.dmem_ack = 1'b0;
    total++; if (hi !== 4) begin bad++; $display("FAIL store_req_cycles got=%0d want=4", hi); end
    total++; if (stable !== 1'b1) begin bad++; $display("FAIL store_stable got=%0b want=1", stable); end
    total++; if (bus.dmem_req !== 1'b0 || bus.imem_addr !== 7'd2) begin bad++; $display("FAIL store_after_ack req=%b pc=%h want req=0 pc=02", bus.dmem_req, bus.imem_addr); end
  endtask

  task automatic test_call_ret();
    fill_nop();
    imem[5] = ins(OP_CALL, 8'h20);
    imem[32] = ins(OP_RET, 8'h00);
    imem[6] = ins(OP_HALT, 8'h00);
    do_reset();
    repeat (10) @(posedge clk); #1;
    total++; if (bus.imem_addr !== 7'h05) begin bad++; $display("FAIL call_pc0 got=%h want=05", bus.imem_addr); end
    repeat (2) @(posedge clk); #1;
    total++; if (bus.imem_addr !== 7'h20) begin bad++; $display("FAIL call_pc1 got=%h want=20", bus.imem_addr); end
    repeat (2) @(posedge clk); #1;
    total++; if (bus.imem_addr !== 7'h06) begin bad++; $display("FAIL call_pc2 got=%h want=06", bus.imem_addr); end
    fill_nop();
    for (int i = 0; i < 5; i++) imem[i] = ins(OP_CALL, 8'(i + 1));
    do_reset();
    repeat (8) @(posedge clk); #1;
    total++; if (bus.imem_addr !== 7'd4 || bus.halted !== 1'b0) begin bad++; $display("FAIL nest_four pc=%h halted=%b want pc=04 halted=0", bus.imem_addr, bus.halted); end
    repeat (2) @(posedge clk); #1;
    total++; if (bus.halted !== 1'b1 || bus.err !== 1'b1 || bus.imem_addr !== 7'd4) begin bad++; $display("FAIL nest_overflow got=%b%b pc=%h want=11 pc=04", bus.halted, bus.err, bus.imem_addr); end
    repeat (3) @(posedge clk); #1;
    total++; if (bus.halted !== 1'b1 || bus.imem_addr !== 7'd4) begin bad++; $display("FAIL nest_absorb halted=%b pc=%h want 1 pc=04", bus.halted, bus.imem_addr); end
  endtask

  task automatic test_ret_empty();
    fill_nop();
    imem[0] = ins(OP_RET, 8'h00);
    do_reset();
    repeat (2) @(posedge clk); #1;
    total++; if (bus.halted !== 1'b1 || bus.err !== 1'b1 || bus.imem_addr !== 7'd0) begin bad++; $display("FAIL ret_empty got=%b%b pc=%h want=11 pc=00", bus.halted, bus.err, bus.imem_addr); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.err !== 1'b0 || bus.halted !== 1'b0 || bus.imem_addr !== 7'd0) begin bad++; $display("FAIL ret_reset got=%b%b pc=%h want=00 pc=00", bus.halted, bus.err, bus.imem_addr); end
    imem[0] = ins(OP_MOV_A, 8'h33);
    imem[1] = ins(OP_HALT, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    total++; if (bus.dbg_a !== 8'h33 || bus.imem_addr !== 7'd1) begin bad++; $display("FAIL ret_restart a=%h pc=%h want a=33 pc=01", bus.dbg_a, bus.imem_addr); end
  endtask

  task automatic test_reset_mid_mem();
    fill_nop();
    imem[0] = ins(OP_LD_A, 8'h30);
    dut_mem[8'h30] = 8'h77;
    do_reset();
    repeat (2) @(posedge clk); #1;
    total++; if (bus.dmem_req !== 1'b1) begin bad++; $display("FAIL midmem_req got=%b want=1", bus.dmem_req); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++; if (bus.dmem_req !== 1'b0) begin bad++; $display("FAIL midmem_drop got=%b want=0", bus.dmem_req); end
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 8'h77;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.dmem_ack = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.dbg_a !== 8'h00 || bus.dbg_b !== 8'h00 || bus.imem_addr !== 7'd0) begin bad++; $display("FAIL midmem_late_ack a=%h b=%h pc=%h want 00 00 00", bus.dbg_a, bus.dbg_b, bus.imem_addr); end
  endtask

  task automatic test_random();
    bit ok;
    int diffs;
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 128; i++) imem[i] = rand_ins();
      for (int i = 0; i < 256; i++) begin dut_mem[i] = 8'($urandom); mdm[i] = int'(dut_mem[i]); end
      do_reset();
      for (int n = 0; n < 60 && !m_halt; n++) begin
        step_instr(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL rand_bus prog=%0d step=%0d got=%0b want=1", p, n, ok); end
        total++; if (bus.imem_addr !== 7'(m_pc)) begin bad++; $display("FAIL rand_pc prog=%0d step=%0d got=%h want=%h", p, n, bus.imem_addr, 7'(m_pc)); end
        total++; if (bus.dbg_a !== 8'(m_a) || bus.dbg_b !== 8'(m_b)) begin bad++; $display("FAIL rand_regs prog=%0d step=%0d got=%h/%h want=%h/%h", p, n, bus.dbg_a, bus.dbg_b, 8'(m_a), 8'(m_b)); end
        total++; if (bus.halted !== m_halt || bus.err !== m_err) begin bad++; $display("FAIL rand_status prog=%0d step=%0d got=%b%b want=%b%b", p, n, bus.halted, bus.err, m_halt, m_err); end
      end
      if (m_halt) begin
        repeat (3) @(posedge clk); #1;
        total++; if (bus.imem_addr !== 7'(m_pc) || bus.dbg_a !== 8'(m_a) || bus.dmem_req !== 1'b0 || bus.halted !== 1'b1) begin bad++; $display("FAIL rand_halt_hold prog=%0d pc=%h a=%h req=%b want pc=%h a=%h req=0", p, bus.imem_addr, bus.dbg_a, bus.dmem_req, 7'(m_pc), 8'(m_a)); end
      end
      diffs = 0;
      for (int i = 0; i < 256; i++) if (dut_mem[i] !== 8'(mdm[i])) diffs++;
      total++; if (diffs !== 0) begin bad++; $display("FAIL rand_dmem prog=%0d differing=%0d want=0", p, diffs); end
    end
  endtask

  initial begin
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;
    test_reset();
    test_add_literal();
    test_carry_flags();
    test_store_wait();
    test_call_ret();
    test_ret_empty();
    test_reset_mid_mem();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
